// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: pixel-rate divider, scan counters and
// registered sync/visible-area decodes aligned with the pixel coordinates.
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] div_cnt;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       line_end;
    logic       frame_wrap;

    // Decodes use the next-state counts so registered outputs line up with pixel_x/pixel_y.
    always_comb begin
        line_end   = p_tick && (pixel_x == H_LAST);
        frame_wrap = line_end && (pixel_y == V_LAST);
        x_next     = pixel_x;
        y_next     = pixel_y;
        if (p_tick) begin
            x_next = line_end ? 10'd0 : pixel_x + 10'd1;
        end
        if (line_end) begin
            y_next = frame_wrap ? 10'd0 : pixel_y + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= 10'd0;
            p_tick      <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= (div_cnt == DIV_LAST) ? 10'd0 : div_cnt + 10'd1;
            p_tick      <= (div_cnt == DIV_LAST);
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync       <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync       <= !((y_next >= VS_START) && (y_next < VS_END));
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync on a scaled-down raster; a closed-form model of the
// expected outputs feeds a scoreboard compared every clock.
module tb_vga_sync;

    localparam int CLK_DIV = 4;
    localparam int HD = 16, HF = 2, HS = 4, HB = 3;
    localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int LINE_CLK  = HT * CLK_DIV;
    localparam int FRAME_CLK = HT * VT * CLK_DIV;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick, video_on, hsync, vsync, frame_start;
    logic [9:0] pixel_x, pixel_y;

    obs_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n        = 0;
    int   mx, my;
    int   von_cnt = 0, vs_low = 0, hs_low_frame = 0, hs_low_line = 0, tick_cnt = 0;
    int   fs_seen = 0, fs_first = 0, fs_second = 0;
    bit   phase1 = 1'b0;
    bit   found;

    vga_sync #(
        .CLK_DIV(CLK_DIV),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic obs_t model(input int cyc);
        obs_t e;
        int   p;
        if (cyc == 0) begin
            e = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        end else begin
            p        = (cyc - 1) / CLK_DIV;
            e.x      = 10'(p % HT);
            e.y      = 10'((p / HT) % VT);
            e.p_tick = (cyc % CLK_DIV) == 0;
            e.von    = (int'(e.x) < HD) && (int'(e.y) < VD);
            e.hs     = !((int'(e.x) >= HD + HF) && (int'(e.x) < HD + HF + HS));
            e.vs     = !((int'(e.y) >= VD + VF) && (int'(e.y) < VD + VF + VS));
            e.fs     = (p > 0) && ((cyc - 1) % CLK_DIV == 0) && (p % (HT * VT) == 0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input int got, input int want);
        n_assert++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        obs_t e, got;
        @(posedge clk);
        n = reset ? n + 1 : 0;
        exp_q.push_back(model(n));
        mx = (n == 0) ? 0 : ((n - 1) / CLK_DIV) % HT;
        my = (n == 0) ? 0 : (((n - 1) / CLK_DIV) / HT) % VT;
        @(negedge clk);
        got = '{p_tick: p_tick, x: pixel_x, y: pixel_y, von: video_on,
                hs: hsync, vs: vsync, fs: frame_start};
        e = exp_q.pop_front();
        n_assert++;
        assert (got === e)
        else begin
            n_fail++;
            $error("FAIL cycle n=%0d: observed tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b expected tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b",
                   n, got.p_tick, got.x, got.y, got.von, got.hs, got.vs, got.fs,
                   e.p_tick, e.x, e.y, e.von, e.hs, e.vs, e.fs);
        end
        if (phase1 && n >= 1 && n <= FRAME_CLK) begin
            von_cnt      += int'(video_on);
            vs_low       += int'(!vsync);
            hs_low_frame += int'(!hsync);
            tick_cnt     += int'(p_tick);
            if (n <= LINE_CLK) hs_low_line += int'(!hsync);
        end
        if (phase1 && frame_start) begin
            fs_seen++;
            if (fs_seen == 1) fs_first = n;
            if (fs_seen == 2) fs_second = n;
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        phase1 = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLK + 3 * CLK_DIV; i++) step();
        phase1 = 1'b0;

        check("hsync_low_clk_first_line", hs_low_line, HS * CLK_DIV);
        check("hsync_low_clk_frame", hs_low_frame, HS * CLK_DIV * VT);
        check("vsync_low_clk_frame", vs_low, VS * LINE_CLK);
        check("video_on_clk_frame", von_cnt, HD * VD * CLK_DIV);
        check("p_tick_count_frame", tick_cnt, HT * VT);
        check("frame_start_count", fs_seen, 2);
        check("first_frame_start_cycle", fs_first, FRAME_CLK + 1);
        check("frame_interval", fs_second - fs_first, FRAME_CLK);

        // Walk to the middle of the visible area, then pulse reset for one clk.
        found = 1'b0;
        for (int i = 0; i < FRAME_CLK + LINE_CLK && !found; i++) begin
            step();
            if (mx == HD / 2 && my == VD / 2) found = 1'b1;
        end
        check("reached_mid_frame", int'(found), 1);
        reset = 1'b0;
        step();
        check("midreset_pixel_x", int'(pixel_x), 0);
        check("midreset_pixel_y", int'(pixel_y), 0);
        check("midreset_video_on", int'(video_on), 0);
        reset = 1'b1;
        for (int i = 0; i < 2 * LINE_CLK; i++) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the 640x480 @ 60 Hz VGA output path. It divides the system clock down to the pixel rate and runs the horizontal and vertical scan counters. From those counters it produces hsync/vsync and the pixel_x/pixel_y/video_on coordinate bus that the text and graphics generators consume. It sits between the board clock and every pixel-painting block, and its coordinates and syncs feed the RGB mux and the VGA connector directly.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz).
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- p_tick  out  1  one-clk pulse per pixel period.
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  vertical count, 0..V_TOTAL-1. Consumers taking 9 bits use [8:0]; this is valid only while video_on=1.
- video_on  out  1  high inside the visible area.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).

## Operation

Derived totals:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
- V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.

Clock divider:
- div_cnt counts 0..CLK_DIV-1, then wraps.
- p_tick = (div_cnt == CLK_DIV-1), asserted for exactly one clk.

Horizontal counter:
- Advances only on p_tick.
- At H_TOTAL-1 it wraps to 0 and raises the line-end condition.

Vertical counter:
- Advances only on line-end.
- At V_TOTAL-1 it wraps to 0.
- Simultaneous wrap of both counters (799,524 to 0,0) sets frame_start for that one clk.

Decodes, all computed from the next-state counter values and registered, so they are aligned with pixel_x/pixel_y:
- video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- hsync = 0 iff H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
- vsync = 0 iff V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.

Width rules:
- All counters are 10 bits.
- No count ever reaches its total; wrap compares use equality with TOTAL-1.

There is no state machine beyond the three counters, and no other enable input.

## Timing

- Reset values while reset=0: div_cnt=0, pixel_x=0, pixel_y=0, p_tick=0, video_on=0, hsync=1, vsync=1, frame_start=0.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk edge, regardless of count position.
- First clk edge after reset release: video_on=1 (counts 0,0), hsync=1, vsync=1.
- First p_tick: on the 4th clk edge after release (div_cnt 0,1,2,3). pixel_x becomes 1 on the edge following that p_tick.
- Each pixel_x value is held for CLK_DIV clocks.
- Line period: 800×4 = 3200 clk. Frame period: 525×3200 = 1,680,000 clk.
- hsync low: 384 clk per line. vsync low: 6400 clk per frame.
- The change of pixel_y coincides with the clk edge on which pixel_x returns to 0.
- frame_start fires on the same edge that both counts become 0. It never fires on the first edge out of reset.
- There is zero latency between a counter value and its decoded video_on/hsync/vsync: same-edge alignment is required.

## Test plan

1. Hold reset=0 for 10 clk, then release → outputs held at reset values during reset. Afterwards p_tick pulses once every 4 clk, the first on clk 4, and pixel_x=1 after the first p_tick.
2. Run one line → pixel_x steps 0..799 then returns to 0. pixel_y increments 0→1 on that same edge. hsync is low exactly while pixel_x ∈ [656,751], a span of 384 clk.
3. Run one full frame → video_on is high only for x<640 and y<480, totalling 307,200 pixel periods. vsync is low only for y ∈ {490,491}, a span of 6400 clk.
4. Run across the frame boundary → the (799,524) to (0,0) transition raises frame_start for exactly 1 clk. The frame-to-frame interval is 1,680,000 clk.
5. Assert reset=0 at position (320,240) for 1 clk → the next edge shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, and counting restarts as in scenario 1.
6. Sweep all positions → at every pixel, video_on/hsync/vsync equal the decode of the pixel_x/pixel_y present on the same clk (scoreboard check).
